// File: rtl/systolic_mm_os.sv
// systolic_mm_os: output-stationary ROWSxCOLS systolic matrix multiply with internal input skew.
// Define SYSTOLIC_OS_SAT_EN to clamp results to the signed OUT_W range instead of wrapping.
module systolic_mm_os #(
  parameter int DATA_W = 16,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_MAX = 16,
  parameter int OUT_W = 2 * DATA_W,
  localparam int ACC_W = 2 * DATA_W + $clog2(K_MAX),
  localparam int KW = $clog2(K_MAX + 1),
  localparam int RW = $clog2(ROWS) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*OUT_W-1:0]  c_row,
  output logic                   out_last
);
  localparam int FL = ROWS + COLS - 2;
  localparam int CW = $clog2(K_MAX + ROWS + COLS + 1);
  localparam int PW = 2 * DATA_W;
  localparam int IW = ROWS > 1 ? $clog2(ROWS) : 1;
`ifdef SYSTOLIC_OS_SAT_EN
  localparam logic signed [ACC_W-1:0] MX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t r_state;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_row;
  logic [KW-1:0] w_klen;
  logic [IW-1:0] w_idx;
  logic w_step, w_clr;
  logic signed [DATA_W-1:0] w_ain [ROWS], w_as [ROWS], w_bin [COLS], w_bs [COLS];
  logic signed [DATA_W-1:0] w_l [ROWS][COLS], w_u [ROWS][COLS];
  logic signed [DATA_W-1:0] r_as [ROWS][ROWS], r_bs [COLS][COLS];
  logic signed [DATA_W-1:0] r_a [ROWS][COLS], r_b [ROWS][COLS];
  logic signed [ACC_W-1:0] r_acc [ROWS][COLS];
  assign w_klen = k_len > KW'(K_MAX) ? KW'(K_MAX) : k_len;
  assign w_clr = r_state == IDLE && start;
  assign w_step = (r_state == LOAD && in_valid) || r_state == FLUSH;
  assign busy = r_state != IDLE;
  assign in_ready = r_state == LOAD;
  assign out_valid = r_state == DRAIN;
  assign out_row = r_row;
  assign out_last = out_valid && r_row == RW'(ROWS - 1);
  assign w_idx = r_row[IW-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k <= '0;
      r_cnt <= '0;
      r_row <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_k <= w_klen;
          r_cnt <= '0;
          r_row <= '0;
          r_state <= w_klen == '0 ? DRAIN : LOAD;
        end
        LOAD: if (in_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt + 1'b1 == CW'(r_k)) begin
            r_cnt <= '0;
            r_state <= FL == 0 ? DRAIN : FLUSH;
          end
        end
        FLUSH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt + 1'b1 == CW'(FL)) begin
            r_cnt <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: if (out_ready) begin
          r_row <= r_row + 1'b1;
          if (r_row == RW'(ROWS - 1)) begin
            r_row <= '0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
  // Row i of A is delayed i steps and column j of B j steps, so operands meet at PE(i,j) in lockstep.
  for (genvar i = 0; i < ROWS; i++) begin : g_ra
    assign w_ain[i] = r_state == LOAD ? a_vec[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_z
      assign w_as[i] = w_ain[i];
    end else begin : g_d
      assign w_as[i] = r_as[i][i-1];
    end
  end
  for (genvar j = 0; j < COLS; j++) begin : g_cb
    assign w_bin[j] = r_state == LOAD ? b_vec[j*DATA_W +: DATA_W] : '0;
    if (j == 0) begin : g_z
      assign w_bs[j] = w_bin[j];
    end else begin : g_d
      assign w_bs[j] = r_bs[j][j-1];
    end
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_pr
    for (genvar j = 0; j < COLS; j++) begin : g_pc
      if (j == 0) begin : g_l0
        assign w_l[i][j] = w_as[i];
      end else begin : g_ln
        assign w_l[i][j] = r_a[i][j-1];
      end
      if (i == 0) begin : g_u0
        assign w_u[i][j] = w_bs[j];
      end else begin : g_un
        assign w_u[i][j] = r_b[i-1][j];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_as <= '{default: '0};
      r_bs <= '{default: '0};
      r_a <= '{default: '0};
      r_b <= '{default: '0};
      r_acc <= '{default: '0};
    end else if (w_step) begin
      for (int i = 0; i < ROWS; i++) begin
        r_as[i][0] <= w_ain[i];
        for (int d = 1; d < ROWS; d++) r_as[i][d] <= r_as[i][d-1];
      end
      for (int j = 0; j < COLS; j++) begin
        r_bs[j][0] <= w_bin[j];
        for (int d = 1; d < COLS; d++) r_bs[j][d] <= r_bs[j][d-1];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          r_a[i][j] <= w_l[i][j];
          r_b[i][j] <= w_u[i][j];
          r_acc[i][j] <= r_acc[i][j] + ACC_W'(PW'(w_l[i][j]) * PW'(w_u[i][j]));
        end
      end
    end
  end
  always_comb begin
    c_row = '0;
    for (int j = 0; j < COLS; j++)
      c_row[j*OUT_W +: OUT_W] = !out_valid ? '0 :
`ifdef SYSTOLIC_OS_SAT_EN
        r_acc[w_idx][j] > MX ? MX[OUT_W-1:0] :
        r_acc[w_idx][j] < MN ? MN[OUT_W-1:0] :
`endif
        r_acc[w_idx][j][OUT_W-1:0];
  end
endmodule

// File: tb/tb_systolic_mm_os.sv
// tb_systolic_mm_os: directed self-checking bench for the 4x4 systolic_mm_os engine.
module tb_systolic_mm_os;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [4:0] k_len = '0;
  logic [63:0] a_vec = '0, b_vec = '0;
  logic busy, in_ready, out_valid, out_last;
  logic [2:0] out_row;
  logic [127:0] c_row;
  int pass_cnt = 0, total_cnt = 0;
  logic [63:0] va [16], vb [16];
  logic [127:0] got [4];
  logic [2:0] got_idx [4];
  logic [3:0] got_last;
  int n_got;
  systolic_mm_os dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .c_row(c_row), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] id_row(input int r);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(4 * r + j + 1);
    return v;
  endfunction
  task automatic set_identity();
    for (int k = 0; k < 16; k++) begin
      va[k] = '0;
      vb[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      va[k][k*16 +: 16] = 16'd1;
      for (int j = 0; j < 4; j++) vb[k][j*16 +: 16] = 16'(4 * k + j + 1);
    end
  endtask
  task automatic do_start(input int k);
    start = 1;
    k_len = 5'(k);
    tick();
    start = 0;
  endtask
  task automatic feed(input int nb, input bit bub, input bit wt, output int lat);
    int n = 0, g = 0;
    bit tog = 0, hs;
    out_ready = 0;
    while (n < nb && g < 200) begin
      in_valid = bub ? tog : 1'b1;
      tog = !tog;
      a_vec = va[n];
      b_vec = vb[n];
      hs = in_valid && in_ready;
      tick();
      g++;
      if (hs) n++;
    end
    in_valid = 0;
    lat = 1;
    if (wt) while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic collect(input int n);
    int g = 0;
    n_got = 0;
    got_last = '0;
    out_ready = 1;
    while (n_got < n && g < 60) begin
      if (out_valid) begin
        got[n_got] = c_row;
        got_idx[n_got] = out_row;
        got_last[n_got] = out_last;
        n_got++;
      end
      tick();
      g++;
    end
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    total_cnt++;
    if ({busy, in_ready, out_valid, out_row, c_row, out_last} !== '0)
      $display("FAIL reset_outputs: got busy=%b rdy=%b ov=%b row=%0d c=%h last=%b want all 0",
               busy, in_ready, out_valid, out_row, c_row, out_last);
    else pass_cnt++;
  endtask
  task automatic test_identity();
    int lat;
    set_identity();
    do_start(4);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL id_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    feed(4, 0, 1, lat);
    total_cnt++;
    if (lat !== 7) $display("FAIL id_latency: got %0d want 7", lat);
    else pass_cnt++;
    collect(4);
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (got[r] !== id_row(r) || got_idx[r] !== 3'(r))
        $display("FAIL id_row%0d: got idx=%0d c=%h want idx=%0d c=%h", r, got_idx[r], got[r], r, id_row(r));
      else pass_cnt++;
    end
    total_cnt++;
    if (got_last !== 4'b1000) $display("FAIL id_last: got %b want 1000", got_last);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL id_busy_fall: got %b want 0", busy);
    else pass_cnt++;
  endtask
  task automatic test_bubbles();
    int lat;
    set_identity();
    do_start(4);
    feed(4, 1, 1, lat);
    total_cnt++;
    if (lat !== 7) $display("FAIL bub_latency: got %0d want 7", lat);
    else pass_cnt++;
    collect(4);
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (got[r] !== id_row(r)) $display("FAIL bub_row%0d: got %h want %h", r, got[r], id_row(r));
      else pass_cnt++;
    end
  endtask
  task automatic test_backpressure();
    int lat;
    set_identity();
    do_start(4);
    feed(4, 0, 1, lat);
    total_cnt++;
    if ({out_valid, out_row} !== {1'b1, 3'd0}) $display("FAIL bp_row0: got ov=%b row=%0d want ov=1 row=0", out_valid, out_row);
    else pass_cnt++;
    out_ready = 1;
    tick();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({out_valid, out_row, c_row} !== {1'b1, 3'd1, id_row(1)})
        $display("FAIL bp_hold%0d: got ov=%b row=%0d c=%h want ov=1 row=1 c=%h", c, out_valid, out_row, c_row, id_row(1));
      else pass_cnt++;
      tick();
    end
    collect(3);
    for (int r = 0; r < 3; r++) begin
      total_cnt++;
      if (got[r] !== id_row(r + 1) || got_idx[r] !== 3'(r + 1))
        $display("FAIL bp_row%0d: got idx=%0d c=%h want idx=%0d c=%h", r + 1, got_idx[r], got[r], r + 1, id_row(r + 1));
      else pass_cnt++;
    end
  endtask
  task automatic test_overflow();
    int lat;
    logic [127:0] exp_c;
`ifdef SYSTOLIC_OS_SAT_EN
    exp_c = {4{32'h7FFFFFFF}};
`else
    exp_c = '0;
`endif
    for (int k = 0; k < 16; k++) begin
      va[k] = {4{16'h8000}};
      vb[k] = {4{16'h8000}};
    end
    do_start(16);
    feed(16, 0, 1, lat);
    collect(4);
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (got[r] !== exp_c) $display("FAIL ovf_row%0d: got %h want %h", r, got[r], exp_c);
      else pass_cnt++;
    end
  endtask
  task automatic test_zero_len();
    do_start(0);
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b10) $display("FAIL zero_start: got ov=%b rdy=%b want ov=1 rdy=0", out_valid, in_ready);
    else pass_cnt++;
    collect(4);
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (got[r] !== '0 || got_idx[r] !== 3'(r)) $display("FAIL zero_row%0d: got idx=%0d c=%h want idx=%0d c=0", r, got_idx[r], got[r], r);
      else pass_cnt++;
    end
  endtask
  task automatic test_reset_mid();
    int lat;
    for (int k = 0; k < 16; k++) begin
      va[k] = {4{16'd5}};
      vb[k] = {4{16'd7}};
    end
    do_start(4);
    feed(2, 0, 0, lat);
    rst = 1;
    tick();
    total_cnt++;
    if ({busy, in_ready, out_valid, out_row, c_row, out_last} !== '0)
      $display("FAIL midrst_outputs: got busy=%b rdy=%b ov=%b row=%0d c=%h last=%b want all 0",
               busy, in_ready, out_valid, out_row, c_row, out_last);
    else pass_cnt++;
    rst = 0;
    tick();
    set_identity();
    do_start(4);
    feed(4, 0, 1, lat);
    total_cnt++;
    if (lat !== 7) $display("FAIL midrst_latency: got %0d want 7", lat);
    else pass_cnt++;
    collect(4);
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (got[r] !== id_row(r)) $display("FAIL midrst_row%0d: got %h want %h", r, got[r], id_row(r));
      else pass_cnt++;
    end
  endtask
  initial begin
    tick();
    test_reset();
    test_identity();
    test_bubbles();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/systolic_mm_os.md
# systolic_mm_os

Parametrised output-stationary systolic matrix-multiply engine computing C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] for a runtime K ≤ K_MAX. Operands arrive as a valid/ready stream: one A column and one B row per beat. Input skewing is internal, and the array advances only on accepted beats. Results drain one row per beat over a second valid/ready stream. The block sits between the operand-fetch DMA and the result writeback in the accelerator datapath.

## Interface
- DATA_W, 16: signed operand width.
- ROWS, 4: PE rows (≥1).
- COLS, 4: PE columns (≥1).
- K_MAX, 16: maximum reduction length.
- OUT_W, 2*DATA_W: result element width.
- ACC_W (localparam), 2*DATA_W+$clog2(K_MAX): internal accumulator width.
- KW (localparam), $clog2(K_MAX+1): width of k_len.
- clk  in  1  single clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  accepted only in IDLE; latches k_len and clears all accumulators.
- k_len  in  KW  reduction length for this job; values above K_MAX are clamped to K_MAX.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- a_vec  in  ROWS*DATA_W  A column k; row i at bits [i*DATA_W +: DATA_W].
- b_vec  in  COLS*DATA_W  B row k; column j at bits [j*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  result sink ready.
- out_row  out  $clog2(ROWS)+1  index of the presented row.
- c_row  out  COLS*OUT_W  C[out_row][*]; column j at bits [j*OUT_W +: OUT_W].
- out_last  out  1  high with row ROWS-1.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: on start, go to LOAD if k_len>0; otherwise go straight to DRAIN, which emits all-zero rows.
- LOAD: each handshake (in_valid & in_ready) is one beat. Each beat pushes a_vec/b_vec into the skew registers and steps the whole array by one. After the k_len-th beat, go to FLUSH, or to DRAIN if ROWS+COLS-2 = 0.
- FLUSH: runs exactly ROWS+COLS-2 cycles. The array steps every cycle with zero operands injected. Afterwards go to DRAIN.
- DRAIN: presents rows 0..ROWS-1 in order. The row advances on out_valid & out_ready. The handshake on the last row returns the FSM to IDLE.
- Skew: A row i is delayed i steps; B column j is delayed j steps. Skew registers and PE operand registers move only on a step.
- PE(i,j): on each step, acc += a·b as a signed full-precision product added into ACC_W bits. It forwards a to the right and b downward.
- Injected zeros and skew fill values are 0, so they add nothing to the result.
- Output width: results are reduced from ACC_W to OUT_W as set by SYSTOLIC_OS_SAT_EN.
- start while busy is ignored.
- in_valid outside LOAD is ignored.
- Beats beyond k_len are never accepted, because in_ready drops after the k_len-th handshake.

## Timing
- Reset value of every output is 0: busy, in_ready, out_valid, out_row, c_row, out_last. The FSM resets to IDLE and all accumulators and skew registers reset to 0.
- Reset mid-operation discards the job. The next cycle is IDLE with all outputs 0.
- in_ready rises the cycle after start is accepted.
- in_valid bubbles stall the array with no loss of data.
- Let t be the cycle of the final LOAD handshake. out_valid rises at cycle t+ROWS+COLS-1, which is 7 cycles after t for 4×4.
- With k_len=0, out_valid rises the cycle after start.
- c_row, out_row and out_last stay stable while out_valid & !out_ready.
- Peak throughput: 1 operand beat per cycle and 1 result row per cycle.
- busy falls the cycle after the last output handshake.
- start is accepted in the same cycle busy is observed low.

## Configuration
- SYSTOLIC_OS_SAT_EN defined: each result is clamped to the signed OUT_W range.
  - Results above 2^(OUT_W-1)-1 become 2^(OUT_W-1)-1.
  - Results below -2^(OUT_W-1) become -2^(OUT_W-1).
- SYSTOLIC_OS_SAT_EN undefined: the output is the low OUT_W bits of the accumulator (two's-complement wrap), with no clamp logic.

## Test plan
- Identity product: 4×4, k_len=4, A=I, B[k][j]=4k+j+1, in_valid held high. Required: rows equal B (row 0 = 1,2,3,4 … row 3 = 13,14,15,16); out_valid at t+7; out_last on row 3.
- Input bubbles: same data as the identity test with in_valid toggling every cycle. Required: identical C; out_valid 7 cycles after the 4th accepted beat.
- Output backpressure: out_ready low for 3 cycles while row 1 is presented. Required: out_row=1 and c_row held constant throughout; all 4 rows eventually delivered in order.
- Overflow: k_len=16, all A and B elements = -32768, so the true sum is 2^34.
  - Macro defined: every element = 0x7FFFFFFF.
  - Macro undefined: every element = 0.
- Zero length: start with k_len=0. Required: in_ready never asserts; 4 zero rows delivered from the cycle after start.
- Reset mid-LOAD: assert rst after 2 beats. Required: all outputs 0 the next cycle. A fresh identity job afterwards gives the correct result with no residue from the aborted job.
